// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for a 5-stage Y86-64 pipeline.
//
// Looks at the current pipeline-register contents and drives the stall/bubble
// controls for the F/D/E/M/W registers. It covers load/use, ret,
// mispredicted jXX and exception handling. It also gates condition-code
// writes and runs a run/halt state machine.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle pulse, IDLE -> RUN
//   D_icode, d_srcA/B   decode-stage icode and source registers (15 = none)
//   E_icode, E_dstM     execute-stage icode and load destination
//   e_Cnd               execute condition result
//   M_icode, m_stat     memory-stage icode and status
//   W_stat              write-back status
//   F_stall .. W_stall  pipeline-register hold/clear controls
//   set_cc              allow condition-code write in execute
//   cpu_state           0 IDLE, 1 RUN, 2 HALTED (FSM state, exposed directly)
//   cpu_stat            final status latched when the machine halts
//   cycle_cnt, lu_cnt, misp_cnt  saturating performance counters
//
// Optional feature: define PIPE_PERF_CNT_EN to build the performance counters.
// When it is undefined the counter outputs are tied to 0 and no flops exist.

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [1:0]       cpu_state,
    output logic [3:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] misp_cnt
);

    localparam logic [3:0] I_OPQ   = 4'd6;
    localparam logic [3:0] I_JXX   = 4'd7;
    localparam logic [3:0] I_RET   = 4'd9;
    localparam logic [3:0] I_MRMOV = 4'd5;
    localparam logic [3:0] I_POP   = 4'd11;
    localparam logic [3:0] R_NONE  = 4'd15;
    localparam logic [3:0] S_AOK   = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state, state_next;

    logic lu, lu_eff, ret, misp, mexc, wexc;

    // HLT, ADR and INS are the exceptional status codes (2..4).
    function automatic logic is_exc(input logic [3:0] s);
        return (s == 4'd2) || (s == 4'd3) || (s == 4'd4);
    endfunction

    assign lu = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != R_NONE)
             && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign misp = (E_icode == I_JXX) && !e_Cnd;
    assign mexc = is_exc(m_stat);
    assign wexc = is_exc(W_stat);

    // A mispredict squashes the instruction in D, so a load/use hazard seen
    // against it is void; this also keeps D_stall and D_bubble exclusive.
    assign lu_eff = lu && !misp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cpu_stat <= S_AOK;
        end else begin
            state <= state_next;
            if ((state == ST_RUN) && wexc) begin
                cpu_stat <= W_stat;
            end
        end
    end

    always_comb begin
        state_next = state;
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        D_bubble   = 1'b0;
        E_bubble   = 1'b0;
        M_bubble   = 1'b0;
        W_stall    = 1'b0;
        set_cc     = 1'b0;
        case (state)
            ST_IDLE: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                F_stall  = lu_eff || ret;
                D_stall  = lu_eff;
                D_bubble = misp || (!lu_eff && ret);
                E_bubble = misp || lu_eff;
                M_bubble = mexc || wexc;
                W_stall  = wexc;
                set_cc   = (E_icode == I_OPQ) && !mexc && !wexc;
                if (wexc) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // Freeze the front of the pipe and keep M empty so nothing
                // further reaches memory or write-back.
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                M_bubble = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cpu_state = state;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic en);
        return (en && (c != '1)) ? c + CNT_ONE : c;
    endfunction

    logic run;
    assign run = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            lu_cnt    <= '0;
            misp_cnt  <= '0;
        end else begin
            cycle_cnt <= sat_inc(cycle_cnt, run);
            lu_cnt    <= sat_inc(lu_cnt, run && lu_eff);
            misp_cnt  <= sat_inc(misp_cnt, run && misp);
        end
    end
`else
    assign cycle_cnt = '0;
    assign lu_cnt    = '0;
    assign misp_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN = 1;
    localparam int ST_HALTED = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start;
    logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
    logic             e_Cnd;
    logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic [1:0]       cpu_state;
    logic [3:0]       cpu_stat;
    logic [CNT_W-1:0] cycle_cnt, lu_cnt, misp_cnt;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .cpu_state(cpu_state), .cpu_stat(cpu_stat),
        .cycle_cnt(cycle_cnt), .lu_cnt(lu_cnt), .misp_cnt(misp_cnt)
    );

    // Output bundle order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc
    logic [6:0] outs;
    assign outs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

    typedef struct {
        logic [3:0] d_icode;
        logic [3:0] d_srca;
        logic [3:0] d_srcb;
        logic [3:0] e_icode;
        logic [3:0] e_dstm;
        logic       e_cnd;
        logic [3:0] m_icode;
        logic [3:0] m_stat;
        logic [3:0] w_stat;
    } vin_t;

    typedef struct {
        vin_t       v;
        logic [6:0] exp;
    } vec_t;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int m_state;
    logic [3:0] m_stat_q;
    int m_cyc, m_lu, m_misp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit exc_stat(input logic [3:0] s);
        return (s >= 4'd2) && (s <= 4'd4);
    endfunction

    function automatic bit haz_lu(input vin_t v);
        bit load = (v.e_icode == 4'd5) || (v.e_icode == 4'd11);
        bit used = (v.e_dstm == v.d_srca) || (v.e_dstm == v.d_srcb);
        return load && (v.e_dstm != 4'd15) && used && !haz_misp(v);
    endfunction

    function automatic bit haz_ret(input vin_t v);
        logic [3:0] stages[3];
        stages[0] = v.d_icode;
        stages[1] = v.e_icode;
        stages[2] = v.m_icode;
        foreach (stages[i]) if (stages[i] == 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit haz_misp(input vin_t v);
        return (v.e_icode == 4'd7) && !v.e_cnd;
    endfunction

    // Expected controls described per pipeline register: what each register
    // does this cycle (hold, flush or load normally).
    function automatic logic [6:0] ref_outs(input vin_t v, input int st);
        bit f_hold, d_hold, d_flush, e_flush, m_flush, w_hold, cc;
        bit lu, rt, mp, me, we;
        if (st == ST_IDLE) return 7'b1100010;
        if (st == ST_HALTED) return 7'b1100110;
        lu = haz_lu(v); rt = haz_ret(v); mp = haz_misp(v);
        me = exc_stat(v.m_stat); we = exc_stat(v.w_stat);
        f_hold  = lu || rt;
        d_hold  = lu;
        d_flush = !d_hold && (mp || rt);
        e_flush = mp || lu;
        m_flush = me || we;
        w_hold  = we;
        cc      = (v.e_icode == 4'd6) && !m_flush;
        return {f_hold, d_hold, d_flush, e_flush, m_flush, w_hold, cc};
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef PIPE_PERF_CNT_EN
        int top = (1 << CNT_W) - 1;
        return CNT_W'((n > top) ? top : n);
`else
        return '0;
`endif
    endfunction

    function automatic vin_t nop_in();
        vin_t v;
        v = '{d_icode: 4'd1, d_srca: 4'd15, d_srcb: 4'd15, e_icode: 4'd1, e_dstm: 4'd15,
              e_cnd: 1'b0, m_icode: 4'd1, m_stat: 4'd1, w_stat: 4'd1};
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vin_t v, input logic st);
        start   = st;
        D_icode = v.d_icode; d_srcA = v.d_srca; d_srcB = v.d_srcb;
        E_icode = v.e_icode; E_dstM = v.e_dstm; e_Cnd = v.e_cnd;
        M_icode = v.m_icode; m_stat = v.m_stat; W_stat = v.w_stat;
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_stat_q = 4'd1; m_cyc = 0; m_lu = 0; m_misp = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " cpu_state"}, 32'(cpu_state), 32'(m_state));
        check({tag, " cpu_stat"}, 32'(cpu_stat), 32'(m_stat_q));
        check({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'(exp_cnt(m_cyc)));
        check({tag, " lu_cnt"}, 32'(lu_cnt), 32'(exp_cnt(m_lu)));
        check({tag, " misp_cnt"}, 32'(misp_cnt), 32'(exp_cnt(m_misp)));
    endtask

    // One clock cycle: drive at negedge, check controls, advance the model
    // across the rising edge, then check registered state.
    task automatic step(input vin_t v, input logic st, input bit use_exp,
                        input logic [6:0] exp, input string tag);
        @(negedge clk);
        drive(v, st);
        #1;
        check({tag, " outs"}, 32'(outs), 32'(use_exp ? exp : ref_outs(v, m_state)));
        if (m_state == ST_RUN) begin
            m_cyc++;
            if (haz_lu(v)) m_lu++;
            if (haz_misp(v)) m_misp++;
            if (exc_stat(v.w_stat)) begin
                m_state  = ST_HALTED;
                m_stat_q = v.w_stat;
            end
        end else if (m_state == ST_IDLE && st) begin
            m_state = ST_RUN;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(nop_in(), 1'b0);
        model_reset();
        #1;
        check("reset outs", 32'(outs), 32'(7'b1100010));
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vin_t rand_in();
        vin_t v;
        v.d_icode = 4'($urandom_range(0, 11));
        v.d_srca  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        v.d_srcb  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        v.e_icode = 4'($urandom_range(0, 11));
        v.e_dstm  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        v.e_cnd   = 1'($urandom_range(0, 1));
        v.m_icode = 4'($urandom_range(0, 11));
        v.m_stat  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
        v.w_stat  = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
        return v;
    endfunction

    // ---------------- test ----------------
    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                                input logic [3:0] ei, input logic [3:0] ed, input logic ec,
                                input logic [3:0] mi, input logic [3:0] ms, input logic [3:0] ws,
                                input logic [6:0] exp);
        vec_t r;
        r.v = '{d_icode: di, d_srca: sa, d_srcb: sb, e_icode: ei, e_dstm: ed,
                e_cnd: ec, m_icode: mi, m_stat: ms, w_stat: ws};
        r.exp = exp;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vin_t v;
        int halted_for;
        rst_n = 1'b0;
        drive(nop_in(), 1'b0);
        model_reset();

        //          D  srcA srcB E  dstM cnd M  m  W   F D Db Eb Mb W cc
        tbl.push_back(mk(1, 15, 15, 1, 15, 0, 1, 1, 1, 7'b0000000)); // quiet pipe
        tbl.push_back(mk(1,  3, 15, 5,  3, 0, 1, 1, 1, 7'b1101000)); // mrmov load/use on srcA
        tbl.push_back(mk(1, 15,  4, 11, 4, 0, 1, 1, 1, 7'b1101000)); // pop load/use on srcB
        tbl.push_back(mk(1, 15, 15, 5, 15, 0, 1, 1, 1, 7'b0000000)); // dstM none, no hazard
        tbl.push_back(mk(1,  3,  3, 5,  4, 0, 1, 1, 1, 7'b0000000)); // load to unused reg
        tbl.push_back(mk(9, 15, 15, 1, 15, 0, 1, 1, 1, 7'b1010000)); // ret in D
        tbl.push_back(mk(1, 15, 15, 9, 15, 0, 1, 1, 1, 7'b1010000)); // ret in E
        tbl.push_back(mk(1, 15, 15, 1, 15, 0, 9, 1, 1, 7'b1010000)); // ret in M
        tbl.push_back(mk(9,  3, 15, 7,  3, 0, 1, 1, 1, 7'b1011000)); // mispredict with ret in D
        tbl.push_back(mk(1, 15, 15, 7, 15, 1, 1, 1, 1, 7'b0000000)); // taken jxx, predicted
        tbl.push_back(mk(1, 15, 15, 6, 15, 0, 1, 1, 1, 7'b0000001)); // opq sets cc
        tbl.push_back(mk(9,  3, 15, 5,  3, 0, 1, 1, 1, 7'b1101000)); // load/use beats ret
        tbl.push_back(mk(1, 15, 15, 6, 15, 0, 1, 3, 1, 7'b0000100)); // opq, mem exception
        tbl.push_back(mk(1, 15, 15, 6, 15, 0, 1, 3, 3, 7'b0000110)); // W exception -> halt

        do_reset();
        step(nop_in(), 1'b1, 1'b1, 7'b1100010, "start");
        foreach (tbl[i]) step(tbl[i].v, 1'b0, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));

        // Halted: controls frozen for 10 cycles whatever arrives, start ignored.
        for (int i = 0; i < 10; i++) step(rand_in(), 1'($urandom_range(0, 1)), 1'b1,
                                          7'b1100110, "halted");
        check("halt stat", 32'(cpu_stat), 32'd3);

        // Saturation: 20 quiet RUN cycles on a 4-bit counter.
        do_reset();
        step(nop_in(), 1'b1, 1'b0, 7'b0, "start2");
        for (int i = 0; i < 20; i++) step(nop_in(), 1'b0, 1'b0, 7'b0, "satrun");
        check("sat cycle_cnt", 32'(cycle_cnt), 32'(exp_cnt(21)));

        // Reset dropped between edges in RUN: immediate IDLE, start ignored.
        do_reset();
        step(nop_in(), 1'b1, 1'b0, 7'b0, "start3");
        v = nop_in(); v.e_icode = 4'd7;
        step(v, 1'b0, 1'b0, 7'b0, "pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        model_reset();
        #1;
        check("async rst state", 32'(cpu_state), 32'(ST_IDLE));
        check("async rst outs", 32'(outs), 32'(7'b1100010));
        check_regs("async rst");
        @(posedge clk);
        #1;
        check_regs("rst start ignored");
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Randomized run against the model, restarting after halts.
        step(nop_in(), 1'b1, 1'b0, 7'b0, "start4");
        halted_for = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_state == ST_HALTED) halted_for++;
            if (halted_for > 4) begin
                do_reset();
                halted_for = 0;
                step(rand_in(), 1'b1, 1'b0, 7'b0, "rstart");
            end else begin
                step(rand_in(), 1'($urandom_range(0, 3) == 0), 1'b0, 7'b0, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
